y86_regsel_scoreboard: RTL and testbench
========================================

Name: y86_regsel_scoreboard

Overview:
Decode-stage register selection for the pipelined Y86-64 core, extended with an in-flight destination scoreboard. It computes srcA/srcB/dstE/dstM for the instruction in D. It tracks the destinations of the next NSTAGES downstream instructions. It raises load-use stall/bubble controls and holds fetch for RET_BUBBLES cycles after a ret issues. It sits between the D pipeline register and the E pipeline register / pipeline control logic.

Parameters:
REG_W, 4, register-ID width; must hold NREG.
NREGS, 15, architectural registers; IDs 0..NREGS-1; NREG = 4'hF means "no register".
NSTAGES, 3, tracked downstream stages (E, M, W); minimum 1.
RET_BUBBLES, 3, fetch-hold cycles after ret issue; minimum 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_n_i  in  1  synchronous active-low reset.
D_valid_i  in  1  D register holds a real instruction.
D_icode_i  in  4  icode in D.
D_rA_i  in  REG_W  rA field.
D_rB_i  in  REG_W  rB field.
flush_i  in  1  mispredict squash of the instruction in D.
d_srcA_o  out  REG_W  source A.
d_srcB_o  out  REG_W  source B.
d_dstE_o  out  REG_W  E-destination.
d_dstM_o  out  REG_W  M-destination.
stall_o  out  1  hold F and D (load-use).
bubble_o  out  1  inject bubble into E.
fetch_hold_o  out  1  ret pending; fetch must not advance PC.
busy_mask_o  out  NREGS  bit r = register r is a pending destination in any tracked stage.

Behaviour:
- Interface: one clock (clk_i); reset rst_n_i is synchronous, active-low.
- Selection is combinational. When D_valid_i=0 or the icode is unknown, all four outputs are NREG.
- srcA:
  - rA for CMOVXX, RMMOVQ, OPQ, PUSHQ.
  - RSP for POPQ, RET.
  - otherwise NREG.
- srcB:
  - rB for MRMOVQ, RMMOVQ, OPQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - otherwise NREG.
- dstE:
  - rB for CMOVXX, IRMOVQ, OPQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - otherwise NREG.
- dstM:
  - rA for MRMOVQ, POPQ.
  - otherwise NREG.
- Scoreboard: entries ent[0..NSTAGES-1], each holding {dstE, dstM}. ent[0] is the instruction currently in E.
  - Every cycle, ent[k+1] <= ent[k], and ent[NSTAGES-1] is discarded.
  - ent[0] <= {d_dstE_o, d_dstM_o} when issue = D_valid_i & ~stall_o & ~flush_i.
  - Otherwise ent[0] <= {NREG, NREG}.
- Hazard (combinational): ent[0].dstM != NREG and it equals a non-NREG d_srcA_o or d_srcB_o.
  - stall_o = hazard & ~flush_i.
  - bubble_o = hazard | flush_i.
  - A stall lasts exactly 1 cycle for a single load-use pair, because the producer shifts to ent[1] on the next cycle.
- Ret hold: 2-state FSM, IDLE and HOLD, with counter ret_cnt of width clog2(RET_BUBBLES+1).
  - IDLE -> HOLD when issue and D_icode_i==RET; ret_cnt <= RET_BUBBLES.
  - In HOLD, fetch_hold_o=1 and ret_cnt decrements each cycle.
  - HOLD -> IDLE on the cycle ret_cnt==1, giving exactly RET_BUBBLES hold cycles.
  - A stalled ret loads the counter only on the cycle it issues.
  - flush_i in HOLD forces IDLE next cycle (flush wins).
- busy_mask_o is registered. It is computed from the next-state entries so it reflects ent[] in the same cycle. Bit r is set if any entry's dstE==r or dstM==r. NREG sets no bit.
- Simultaneous events: flush_i overrides hazard (stall_o=0, bubble_o=1, no issue). A hazard with D_icode_i==RET causes the ret to stall, not issue.
- Reset (rst_n_i=0 at an edge): all entries {NREG, NREG}, FSM IDLE, ret_cnt=0, busy_mask_o=0. Hence stall_o=0, bubble_o=0, fetch_hold_o=0. A reset mid-HOLD aborts the hold.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (HALT..POPQ).
  - NREG and RSP.
  - the scoreboard entry struct {dstE, dstM}.
  - the ret FSM state enum.
- One sub-module: y86_inflight_pipe. It is the NSTAGES-deep entry shift register with a push/bubble input and a busy-mask/ent[0] output. The top level holds selection, hazard, and ret FSM.

Test Plan:
- Reset, then D_valid_i=1 with OPQ rA=2 rB=3 -> srcA=2, srcB=3, dstE=3, dstM=F; next cycle busy_mask_o=0x0008; no stall.
- MRMOVQ rA=5 followed by OPQ rA=5 rB=1 -> stall_o=1 and bubble_o=1 for exactly 1 cycle; OPQ issues next cycle; ent[0]=NREG in between.
- MRMOVQ rA=5 then an unrelated instruction, then OPQ using r5 (distance 2) -> no stall; busy bit 5 clears after NSTAGES+1 cycles.
- RET issue with RET_BUBBLES=3 -> fetch_hold_o high for exactly 3 cycles; srcA=srcB=dstE=4 (RSP) at issue.
- Load-use hazard with flush_i=1 in the same cycle -> stall_o=0, bubble_o=1, no entry pushed; flush during HOLD -> fetch_hold_o drops next cycle.
- rst_n_i=0 for one edge mid-HOLD with busy_mask_o nonzero -> all outputs 0 next cycle; D_icode_i=0xC (invalid) -> all selects F, no hazard.

Source files
------------

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the Y86-64 decode-stage register selection and the
// in-flight destination scoreboard.
//   - instruction codes (HALT..POPQ)
//   - register IDs: NREG ("no register") and RSP (stack pointer)
//   - sb_entry_t: one scoreboard slot holding the {dstE, dstM} of an
//     instruction that has left decode
//   - ret_state_t: states of the ret fetch-hold FSM
// -----------------------------------------------------------------------------
package y86_pkg;

   localparam int REG_ID_W = 4;

   typedef logic [REG_ID_W-1:0] reg_id_t;

   localparam reg_id_t NREG = 4'hF;
   localparam reg_id_t RSP  = 4'h4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef struct packed {
      reg_id_t dstE;
      reg_id_t dstM;
   } sb_entry_t;

   // A slot that names no destination; this is what a bubble carries.
   localparam sb_entry_t SB_EMPTY = '{dstE: NREG, dstM: NREG};

   typedef enum logic {
      RET_IDLE,
      RET_HOLD
   } ret_state_t;

endpackage

// File: rtl/y86_inflight_pipe.sv
// -----------------------------------------------------------------------------
// y86_inflight_pipe
// NSTAGES-deep shift register of destination entries for the instructions
// downstream of decode (slot 0 = the instruction now in E). Each cycle the
// entries advance by one and the oldest falls off the end; slot 0 takes the
// pushed entry, or an empty entry when nothing issues.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (all slots emptied)
//   push      in   an instruction issues from D this cycle
//   push_ent  in   {dstE, dstM} of the issuing instruction
//   head      out  current slot 0 (the instruction in E)
//   busy_mask out  registered: bit r set when any slot names register r
// -----------------------------------------------------------------------------
module y86_inflight_pipe
   import y86_pkg::*;
#(
   parameter int NSTAGES = 3,
   parameter int NREGS   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  sb_entry_t        push_ent,
   output sb_entry_t        head,
   output logic [NREGS-1:0] busy_mask
);

   sb_entry_t        ent     [NSTAGES];
   sb_entry_t        ent_nxt [NSTAGES];
   logic [NREGS-1:0] mask_nxt;

   // Next contents of the pipe: a new entry (or a bubble) enters slot 0 and
   // everything else moves one stage further downstream.
   always_comb begin
      ent_nxt[0] = push ? push_ent : SB_EMPTY;
      for (int k = 1; k < NSTAGES; k++) begin
         ent_nxt[k] = ent[k-1];
      end
   end

   // The busy mask is built from the next-state entries so that, once
   // registered, it describes exactly the entries held during that cycle.
   // NREG lies outside 0..NREGS-1 and therefore never sets a bit.
   always_comb begin
      mask_nxt = '0;
      for (int r = 0; r < NREGS; r++) begin
         for (int k = 0; k < NSTAGES; k++) begin
            if (ent_nxt[k].dstE == reg_id_t'(r) || ent_nxt[k].dstM == reg_id_t'(r)) begin
               mask_nxt[r] = 1'b1;
            end
         end
      end
   end

   // Entry storage and registered busy mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGES; k++) begin
            ent[k] <= SB_EMPTY;
         end
         busy_mask <= '0;
      end else begin
         for (int k = 0; k < NSTAGES; k++) begin
            ent[k] <= ent_nxt[k];
         end
         busy_mask <= mask_nxt;
      end
   end

   assign head = ent[0];

endmodule

// File: rtl/y86_regsel_scoreboard.sv
// -----------------------------------------------------------------------------
// y86_regsel_scoreboard
// Decode-stage register selection for the pipelined Y86-64 core, with an
// in-flight destination scoreboard, load-use stall/bubble generation and a
// fetch hold of RET_BUBBLES cycles after a ret issues.
// Ports:
//   clk_i         in   rising-edge clock
//   rst_n_i       in   synchronous active-low reset
//   D_valid_i     in   D holds a real instruction
//   D_icode_i     in   icode in D
//   D_rA_i        in   rA field
//   D_rB_i        in   rB field
//   flush_i       in   mispredict squash of the instruction in D
//   d_srcA_o      out  source A register (NREG when none)
//   d_srcB_o      out  source B register
//   d_dstE_o      out  E-destination register
//   d_dstM_o      out  M-destination register
//   stall_o       out  hold F and D (load-use)
//   bubble_o      out  inject a bubble into E
//   fetch_hold_o  out  ret pending, fetch must not advance the PC
//   busy_mask_o   out  bit r = register r is a pending destination downstream
// -----------------------------------------------------------------------------
module y86_regsel_scoreboard
   import y86_pkg::*;
#(
   parameter int REG_W       = 4,
   parameter int NREGS       = 15,
   parameter int NSTAGES     = 3,
   parameter int RET_BUBBLES = 3
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             D_valid_i,
   input  logic [3:0]       D_icode_i,
   input  logic [REG_W-1:0] D_rA_i,
   input  logic [REG_W-1:0] D_rB_i,
   input  logic             flush_i,
   output logic [REG_W-1:0] d_srcA_o,
   output logic [REG_W-1:0] d_srcB_o,
   output logic [REG_W-1:0] d_dstE_o,
   output logic [REG_W-1:0] d_dstM_o,
   output logic             stall_o,
   output logic             bubble_o,
   output logic             fetch_hold_o,
   output logic [NREGS-1:0] busy_mask_o
);

   localparam int CNT_W = $clog2(RET_BUBBLES + 1);

   reg_id_t    src_a;
   reg_id_t    src_b;
   reg_id_t    dst_e;
   reg_id_t    dst_m;
   sb_entry_t  head;
   reg_id_t    load_dst;
   logic       hazard;
   logic       issue;
   ret_state_t state;
   logic [CNT_W-1:0] ret_cnt;

   // Register selection from icode/rA/rB. Anything not a valid instruction,
   // including icodes beyond POPQ, selects no register at all.
   always_comb begin
      src_a = NREG;
      src_b = NREG;
      dst_e = NREG;
      dst_m = NREG;
      if (D_valid_i) begin
         case (D_icode_i)
            I_CMOVXX: begin
               src_a = D_rA_i;
               dst_e = D_rB_i;
            end
            I_IRMOVQ: begin
               dst_e = D_rB_i;
            end
            I_RMMOVQ: begin
               src_a = D_rA_i;
               src_b = D_rB_i;
            end
            I_MRMOVQ: begin
               src_b = D_rB_i;
               dst_m = D_rA_i;
            end
            I_OPQ: begin
               src_a = D_rA_i;
               src_b = D_rB_i;
               dst_e = D_rB_i;
            end
            I_CALL: begin
               src_b = RSP;
               dst_e = RSP;
            end
            I_RET: begin
               src_a = RSP;
               src_b = RSP;
               dst_e = RSP;
            end
            I_PUSHQ: begin
               src_a = D_rA_i;
               src_b = RSP;
               dst_e = RSP;
            end
            I_POPQ: begin
               src_a = RSP;
               src_b = RSP;
               dst_e = RSP;
               dst_m = D_rA_i;
            end
            default: begin
            end
         endcase
      end
   end

   assign d_srcA_o = src_a;
   assign d_srcB_o = src_b;
   assign d_dstE_o = dst_e;
   assign d_dstM_o = dst_m;

   // Load-use: only the instruction in E can still be waiting on memory for
   // a value D wants. One cycle later it sits in M and forwarding covers it,
   // so a single producer/consumer pair stalls for exactly one cycle.
   // A squash in D overrides the stall: the consumer is discarded anyway.
   assign load_dst = head.dstM;
   assign hazard   = (load_dst != NREG) &&
                     (((src_a != NREG) && (src_a == load_dst)) ||
                      ((src_b != NREG) && (src_b == load_dst)));
   assign stall_o  = hazard & ~flush_i;
   assign bubble_o = hazard | flush_i;
   assign issue    = D_valid_i & ~stall_o & ~flush_i;

   y86_inflight_pipe #(
      .NSTAGES (NSTAGES),
      .NREGS   (NREGS)
   ) u_pipe (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .push      (issue),
      .push_ent  ('{dstE: dst_e, dstM: dst_m}),
      .head      (head),
      .busy_mask (busy_mask_o)
   );

   // Ret fetch hold. The counter is loaded only when the ret actually issues
   // (a stalled ret waits), then counts down; the hold ends on the cycle the
   // count reaches 1, giving RET_BUBBLES hold cycles. A flush during the hold
   // cancels it immediately. fetch_hold_o is registered alongside the state.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state        <= RET_IDLE;
         ret_cnt      <= '0;
         fetch_hold_o <= 1'b0;
      end else begin
         case (state)
            RET_IDLE: begin
               if (issue && (D_icode_i == I_RET)) begin
                  state        <= RET_HOLD;
                  ret_cnt      <= CNT_W'(RET_BUBBLES);
                  fetch_hold_o <= 1'b1;
               end
            end
            RET_HOLD: begin
               if (flush_i || (ret_cnt == CNT_W'(1))) begin
                  state        <= RET_IDLE;
                  ret_cnt      <= '0;
                  fetch_hold_o <= 1'b0;
               end else begin
                  ret_cnt <= ret_cnt - CNT_W'(1);
               end
            end
            default: begin
               state        <= RET_IDLE;
               ret_cnt      <= '0;
               fetch_hold_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_y86_regsel_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_y86_regsel_scoreboard
// Self-checking bench for y86_regsel_scoreboard. A behavioural model tracks
// the destinations of the last NSTAGES issued instructions and the number of
// remaining ret hold cycles; a negedge process compares every output against
// it each cycle. Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_y86_regsel_scoreboard;

   localparam int NSTAGES     = 3;
   localparam int RET_BUBBLES = 3;
   localparam int NREGS       = 15;

   localparam logic [3:0] HALT  = 4'h0;
   localparam logic [3:0] NOP   = 4'h1;
   localparam logic [3:0] CMOV  = 4'h2;
   localparam logic [3:0] IRMOV = 4'h3;
   localparam logic [3:0] RMMOV = 4'h4;
   localparam logic [3:0] MRMOV = 4'h5;
   localparam logic [3:0] OPQ   = 4'h6;
   localparam logic [3:0] CALL  = 4'h8;
   localparam logic [3:0] RET   = 4'h9;
   localparam logic [3:0] PUSH  = 4'hA;
   localparam logic [3:0] POP   = 4'hB;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        valid   = 1'b0;
   logic [3:0]  icode   = NOP;
   logic [3:0]  ra      = 4'hF;
   logic [3:0]  rb      = 4'hF;
   logic        flush   = 1'b0;

   logic [3:0]  d_srcA;
   logic [3:0]  d_srcB;
   logic [3:0]  d_dstE;
   logic [3:0]  d_dstM;
   logic        stall;
   logic        bubble;
   logic        fetch_hold;
   logic [14:0] busy_mask;

   int checks   = 0;
   int failures = 0;

   // Model state: pending destinations (15 = none), slot 0 = instruction in E.
   int pendE [NSTAGES];
   int pendM [NSTAGES];
   int holdLeft   = 0;
   bit modelValid = 1'b0;

   logic [15:0] expSel;
   bit          expHz;

   always #5 clk = ~clk;

   y86_regsel_scoreboard #(
      .REG_W       (4),
      .NREGS       (NREGS),
      .NSTAGES     (NSTAGES),
      .RET_BUBBLES (RET_BUBBLES)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .D_valid_i    (valid),
      .D_icode_i    (icode),
      .D_rA_i       (ra),
      .D_rB_i       (rb),
      .flush_i      (flush),
      .d_srcA_o     (d_srcA),
      .d_srcB_o     (d_srcB),
      .d_dstE_o     (d_dstE),
      .d_dstM_o     (d_dstM),
      .stall_o      (stall),
      .bubble_o     (bubble),
      .fetch_hold_o (fetch_hold),
      .busy_mask_o  (busy_mask)
   );

   // Which registers an instruction reads and writes, decided one output at a
   // time from the ISA tables; returns {srcA, srcB, dstE, dstM}.
   function automatic logic [15:0] expectSel(input logic v, input logic [3:0] ic,
                                             input logic [3:0] a, input logic [3:0] b);
      logic [3:0] sa;
      logic [3:0] sb;
      logic [3:0] de;
      logic [3:0] dm;
      sa = 4'hF;
      sb = 4'hF;
      de = 4'hF;
      dm = 4'hF;
      if (v) begin
         if (ic inside {CMOV, RMMOV, OPQ, PUSH}) sa = a;
         else if (ic inside {POP, RET})          sa = 4'h4;
         if (ic inside {MRMOV, RMMOV, OPQ})            sb = b;
         else if (ic inside {PUSH, POP, CALL, RET})    sb = 4'h4;
         if (ic inside {CMOV, IRMOV, OPQ})             de = b;
         else if (ic inside {PUSH, POP, CALL, RET})    de = 4'h4;
         if (ic inside {MRMOV, POP})                   dm = a;
      end
      return {sa, sb, de, dm};
   endfunction

   // D must wait when the load now in E writes a register D reads.
   function automatic bit expectHazard(input logic [15:0] sel);
      int ld;
      ld = pendM[0];
      return (ld != 15) && ((int'(sel[15:12]) == ld) || (int'(sel[11:8]) == ld));
   endfunction

   function automatic logic [14:0] expectBusy();
      logic [14:0] m;
      m = '0;
      for (int k = 0; k < NSTAGES; k++) begin
         if (pendE[k] < NREGS) m[pendE[k]] = 1'b1;
         if (pendM[k] < NREGS) m[pendM[k]] = 1'b1;
      end
      return m;
   endfunction

   function automatic bit modelIssue();
      logic [15:0] s;
      s = expectSel(valid, icode, ra, rb);
      return valid && !flush && !expectHazard(s);
   endfunction

   function automatic int modelNextE();
      logic [15:0] s;
      s = expectSel(valid, icode, ra, rb);
      return modelIssue() ? int'(s[7:4]) : 15;
   endfunction

   function automatic int modelNextM();
      logic [15:0] s;
      s = expectSel(valid, icode, ra, rb);
      return modelIssue() ? int'(s[3:0]) : 15;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] ic, input logic [3:0] a,
                                input logic [3:0] b, input logic f);
      @(posedge clk);
      #1;
      valid = v;
      icode = ic;
      ra    = a;
      rb    = b;
      flush = f;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
   endtask

   // Model update on each rising edge, from the inputs held over the cycle.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGES; k++) begin
            pendE[k] <= 15;
            pendM[k] <= 15;
         end
         holdLeft   <= 0;
         modelValid <= 1'b1;
      end else begin
         for (int k = 1; k < NSTAGES; k++) begin
            pendE[k] <= pendE[k-1];
            pendM[k] <= pendM[k-1];
         end
         pendE[0] <= modelNextE();
         pendM[0] <= modelNextM();
         if (holdLeft > 0)                       holdLeft <= flush ? 0 : holdLeft - 1;
         else if (modelIssue() && icode == RET)  holdLeft <= RET_BUBBLES;
      end
   end

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (modelValid) begin
         expSel = expectSel(valid, icode, ra, rb);
         expHz  = expectHazard(expSel);
         checkOutput("model srcA",   32'(d_srcA),     32'(expSel[15:12]));
         checkOutput("model srcB",   32'(d_srcB),     32'(expSel[11:8]));
         checkOutput("model dstE",   32'(d_dstE),     32'(expSel[7:4]));
         checkOutput("model dstM",   32'(d_dstM),     32'(expSel[3:0]));
         checkOutput("model stall",  32'(stall),      32'(expHz && !flush));
         checkOutput("model bubble", 32'(bubble),     32'(expHz || flush));
         checkOutput("model hold",   32'(fetch_hold), 32'(holdLeft > 0));
         checkOutput("model busy",   32'(busy_mask),  32'(expectBusy()));
      end
   end

   initial begin
      // Reset held over two edges.
      rst_n = 1'b0;
      idleCycles(2);
      #2;
      checkOutput("reset busy",   32'(busy_mask),  32'h0);
      checkOutput("reset stall",  32'(stall),      32'h0);
      checkOutput("reset bubble", 32'(bubble),     32'h0);
      checkOutput("reset hold",   32'(fetch_hold), 32'h0);
      rst_n = 1'b1;

      // Plain OPQ: selection and busy bit of its destination.
      applyStimulus(1'b1, OPQ, 4'h2, 4'h3, 1'b0);
      #2;
      checkOutput("opq srcA",  32'(d_srcA), 32'h2);
      checkOutput("opq srcB",  32'(d_srcB), 32'h3);
      checkOutput("opq dstE",  32'(d_dstE), 32'h3);
      checkOutput("opq dstM",  32'(d_dstM), 32'hF);
      checkOutput("opq stall", 32'(stall),  32'h0);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("opq busy", 32'(busy_mask), 32'h0008);

      // Load-use pair: one stall cycle, then the consumer issues.
      applyStimulus(1'b1, MRMOV, 4'h5, 4'hF, 1'b0);
      #2;
      checkOutput("mrmov dstM", 32'(d_dstM), 32'h5);
      checkOutput("mrmov srcA", 32'(d_srcA), 32'hF);
      applyStimulus(1'b1, OPQ, 4'h5, 4'h1, 1'b0);
      #2;
      checkOutput("loaduse stall",  32'(stall),  32'h1);
      checkOutput("loaduse bubble", 32'(bubble), 32'h1);
      applyStimulus(1'b1, OPQ, 4'h5, 4'h1, 1'b0);
      #2;
      checkOutput("loaduse stall2",  32'(stall),     32'h0);
      checkOutput("loaduse bubble2", 32'(bubble),    32'h0);
      checkOutput("loaduse gapbusy", 32'(busy_mask), 32'h0020);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("loaduse busy", 32'(busy_mask), 32'h0022);

      // Distance-2 consumer: no stall; r5 leaves after NSTAGES+1 edges.
      idleCycles(NSTAGES + 1);
      applyStimulus(1'b1, MRMOV, 4'h5, 4'hF, 1'b0);
      applyStimulus(1'b1, NOP, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b1, OPQ, 4'h5, 4'h1, 1'b0);
      #2;
      checkOutput("dist2 stall", 32'(stall),     32'h0);
      checkOutput("dist2 busy",  32'(busy_mask), 32'h0020);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("dist2 busy2", 32'(busy_mask), 32'h0022);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("dist2 r5 clear", 32'(busy_mask), 32'h0002);

      // Ret: RSP selected, fetch held exactly RET_BUBBLES cycles.
      idleCycles(NSTAGES + 1);
      applyStimulus(1'b1, RET, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret srcA", 32'(d_srcA),     32'h4);
      checkOutput("ret srcB", 32'(d_srcB),     32'h4);
      checkOutput("ret dstE", 32'(d_dstE),     32'h4);
      checkOutput("ret dstM", 32'(d_dstM),     32'hF);
      checkOutput("ret hold0", 32'(fetch_hold), 32'h0);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret hold1", 32'(fetch_hold), 32'h1);
      checkOutput("ret busy",  32'(busy_mask),  32'h0010);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret hold2", 32'(fetch_hold), 32'h1);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret hold3", 32'(fetch_hold), 32'h1);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret hold end", 32'(fetch_hold), 32'h0);

      // Load-use with a flush in the same cycle: bubble only, nothing pushed.
      idleCycles(NSTAGES + 1);
      applyStimulus(1'b1, MRMOV, 4'h5, 4'hF, 1'b0);
      applyStimulus(1'b1, OPQ, 4'h5, 4'h1, 1'b1);
      #2;
      checkOutput("flush stall",  32'(stall),  32'h0);
      checkOutput("flush bubble", 32'(bubble), 32'h1);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("flush busy", 32'(busy_mask), 32'h0020);

      // Flush during the hold drops fetch_hold on the next cycle.
      idleCycles(NSTAGES + 1);
      applyStimulus(1'b1, RET, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b1);
      #2;
      checkOutput("holdflush hold1", 32'(fetch_hold), 32'h1);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("holdflush drop", 32'(fetch_hold), 32'h0);

      // A ret stalled on a pending rsp load starts its hold only once it issues.
      idleCycles(NSTAGES + 1);
      applyStimulus(1'b1, MRMOV, 4'h4, 4'hF, 1'b0);
      applyStimulus(1'b1, RET, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret stall", 32'(stall), 32'h1);
      applyStimulus(1'b1, RET, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret stalled hold", 32'(fetch_hold), 32'h0);
      checkOutput("ret stall done",   32'(stall),      32'h0);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("ret late hold", 32'(fetch_hold), 32'h1);

      // Reset mid-hold with pending destinations clears everything.
      idleCycles(NSTAGES + 2);
      applyStimulus(1'b1, RET, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      #2;
      checkOutput("pre-reset hold", 32'(fetch_hold), 32'h1);
      checkOutput("pre-reset busy", 32'(busy_mask),  32'h0010);
      rst_n = 1'b0;
      applyStimulus(1'b0, NOP, 4'hF, 4'hF, 1'b0);
      rst_n = 1'b1;
      #2;
      checkOutput("midreset hold", 32'(fetch_hold), 32'h0);
      checkOutput("midreset busy", 32'(busy_mask),  32'h0);

      // Unknown icode and invalid D select nothing.
      applyStimulus(1'b1, 4'hC, 4'h2, 4'h3, 1'b0);
      #2;
      checkOutput("badicode sel",   32'({d_srcA, d_srcB, d_dstE, d_dstM}), 32'hFFFF);
      checkOutput("badicode stall", 32'(stall), 32'h0);
      applyStimulus(1'b0, OPQ, 4'h2, 4'h3, 1'b0);
      #2;
      checkOutput("invalid sel", 32'({d_srcA, d_srcB, d_dstE, d_dstM}), 32'hFFFF);

      // Remaining instruction classes go through the model only.
      applyStimulus(1'b1, POP, 4'h7, 4'hF, 1'b0);
      applyStimulus(1'b1, PUSH, 4'h7, 4'hF, 1'b0);
      applyStimulus(1'b1, CALL, 4'hF, 4'hF, 1'b0);
      applyStimulus(1'b1, CMOV, 4'h1, 4'h9, 1'b0);
      applyStimulus(1'b1, IRMOV, 4'hF, 4'hE, 1'b0);
      applyStimulus(1'b1, RMMOV, 4'hE, 4'h9, 1'b0);
      applyStimulus(1'b1, HALT, 4'h3, 4'h3, 1'b0);
      idleCycles(NSTAGES + 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
